cfg_shadow_block: RTL and testbench

CFG_SHADOW_BLOCK -- requirements
Module: cfg_shadow_block

---
 rtl/cfg_pkg.sv | 21 ++
 rtl/cfg_serializer.sv | 40 ++++
 rtl/cfg_shadow_block.sv | 154 +++++++++++++++
 tb/tb_cfg_shadow_block.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared types and helpers for the daisy-chained configuration shadow block.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  // Number of BUS_W-wide beats needed to carry a given number of bits.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Parallel-load shift-out engine that emits a readback frame BUS_W bits per beat.
module cfg_serializer #(
  parameter int BUS_W = 1,
  parameter int BEATS = 2
) (
  input  logic                   clk,
  input  logic                   crst,
  input  logic                   load,
  input  logic [BEATS*BUS_W-1:0] load_data,
  input  logic                   shift,
  output logic [BUS_W-1:0]       beat_data,
  output logic                   first,
  output logic                   last
);

  localparam int FW = BEATS * BUS_W;
  localparam int CW = $clog2(BEATS + 1);

  logic [FW-1:0] sr;
  logic [CW-1:0] remain;

  // remain counts down to the terminal beat of the frame
  always_ff @(posedge clk) begin
    if (crst) begin
      sr     <= '0;
      remain <= '0;
    end else if (load) begin
      sr     <= load_data;
      remain <= CW'(BEATS - 1);
    end else if (shift) begin
      sr <= sr >> BUS_W;
      if (remain != '0) remain <= remain - 1'b1;
    end
  end

  assign beat_data = sr[BUS_W-1:0];
  assign first     = (remain == CW'(BEATS - 1));
  assign last      = (remain == '0);

endmodule

// File: rtl/cfg_shadow_block.sv
// Chained config node: forwards beats downstream, shadows writes to this ID, answers reads.
//   state    | meaning
//   ST_IDLE  | waiting for a start beat, forwarding everything
//   ST_HDR   | collecting the remaining header beats
//   ST_WDATA | shifting payload into the shadow register
//   ST_RESP  | driving the readback frame, input beats dropped
module cfg_shadow_block
  import cfg_pkg::*;
#(
  parameter int CFG_SIZE = 152,
  parameter int BUS_W    = 1,
  parameter int ID_WIDTH = 3,
  parameter int ID       = 0
) (
  input  logic                clk,
  input  logic                crst,
  input  logic                cfg_in_start,
  input  logic [BUS_W-1:0]    cfg_in_data,
  input  logic                cfg_in_valid,
  output logic                cfg_out_start,
  output logic [BUS_W-1:0]    cfg_out_data,
  output logic                cfg_out_valid,
  output logic [CFG_SIZE-1:0] cfg,
  output logic                cfg_sr_pulse,
  output logic                cfg_busy,
  output logic                cfg_err
);

  localparam int HDR_BITS  = ID_WIDTH + 1;
  localparam int HDR_BEATS = ceil_div(HDR_BITS, BUS_W);
  localparam int NBEATS    = ceil_div(CFG_SIZE, BUS_W);
  localparam int HW        = HDR_BEATS * BUS_W;
  localparam int NW        = NBEATS * BUS_W;
  localparam int FW        = HW + NW;
  localparam int CNT_MAX   = (NBEATS > HDR_BEATS) ? NBEATS : HDR_BEATS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int HDR_LAST  = (HDR_BEATS > 1) ? HDR_BEATS - 2 : 0;

  state_e            state, nxt, hdr_target;
  op_e               hdr_op;
  logic [CNT_W-1:0]  cnt;
  logic [HW-1:0]     hdr_sr, hdr_base, hdr_next;
  logic [NW-1:0]     shadow, shadow_next;
  logic [FW-1:0]     resp_frame;
  logic              start_beat, in_frame, abort, hdr_done, id_match, commit;
  logic              ser_load, ser_shift, ser_first, ser_last;
  logic [BUS_W-1:0]  ser_data;

  assign start_beat  = cfg_in_valid && cfg_in_start && (state != ST_RESP);
  assign in_frame    = (state == ST_HDR) || (state == ST_WDATA);
  assign abort       = start_beat && in_frame;
  assign hdr_base    = start_beat ? '0 : hdr_sr;
  assign hdr_next    = HW'({cfg_in_data, hdr_base} >> BUS_W);
  assign shadow_next = NW'({cfg_in_data, shadow} >> BUS_W);
  assign hdr_op      = op_e'(hdr_next[0]);
  assign id_match    = (hdr_next[ID_WIDTH:1] == ID_WIDTH'(ID));
  assign hdr_target  = !id_match ? ST_IDLE : (hdr_op == OP_WRITE) ? ST_WDATA : ST_RESP;

  // A single-beat header is complete on the start beat itself, so the decision is taken there
  assign hdr_done = (start_beat && (HDR_BEATS == 1)) ||
                    ((state == ST_HDR) && cfg_in_valid && !cfg_in_start &&
                     (cnt == CNT_W'(HDR_LAST)));
  assign commit   = (state == ST_WDATA) && cfg_in_valid && !cfg_in_start &&
                    (cnt == CNT_W'(NBEATS - 1));

  always_ff @(posedge clk) begin
    if (crst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state == ST_RESP) begin
      if (ser_last) nxt = ST_IDLE;
    end else if (hdr_done) begin
      nxt = hdr_target;
    end else if (start_beat) begin
      nxt = ST_HDR;
    end else if (commit) begin
      nxt = ST_IDLE;
    end
  end

  always_comb begin
    cfg_busy  = (state != ST_IDLE);
    ser_load  = (nxt == ST_RESP) && (state != ST_RESP);
    ser_shift = (state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (crst)                               cnt <= '0;
    else if ((nxt != state) || start_beat)  cnt <= '0;
    else if (cfg_in_valid && in_frame)      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (crst)                                             hdr_sr <= '0;
    else if (start_beat || ((state == ST_HDR) && cfg_in_valid)) hdr_sr <= hdr_next;
  end

  always_ff @(posedge clk) begin
    if (crst || abort)                              shadow <= '0;
    else if ((state == ST_WDATA) && cfg_in_valid)   shadow <= shadow_next;
  end

  always_ff @(posedge clk) begin
    if (crst) begin
      cfg          <= '0;
      cfg_sr_pulse <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_sr_pulse <= commit;
      if (commit) cfg <= shadow_next[CFG_SIZE-1:0];
      if (abort || ((state == ST_RESP) && cfg_in_valid)) cfg_err <= 1'b1;
    end
  end

  always_comb begin
    resp_frame                    = '0;
    resp_frame[HDR_BITS-1:0]      = {ID_WIDTH'(ID), 1'(OP_READ)};
    resp_frame[HW +: CFG_SIZE]    = cfg;
  end

  cfg_serializer #(
    .BUS_W (BUS_W),
    .BEATS (HDR_BEATS + NBEATS)
  ) u_ser (
    .clk       (clk),
    .crst      (crst),
    .load      (ser_load),
    .load_data (resp_frame),
    .shift     (ser_shift),
    .beat_data (ser_data),
    .first     (ser_first),
    .last      (ser_last)
  );

  always_ff @(posedge clk) begin
    if (crst) begin
      cfg_out_start <= 1'b0;
      cfg_out_data  <= '0;
      cfg_out_valid <= 1'b0;
    end else if (state == ST_RESP) begin
      cfg_out_start <= ser_first;
      cfg_out_data  <= ser_data;
      cfg_out_valid <= 1'b1;
    end else begin
      cfg_out_start <= cfg_in_valid && cfg_in_start;
      cfg_out_data  <= cfg_in_valid ? cfg_in_data : '0;
      cfg_out_valid <= cfg_in_valid;
    end
  end

endmodule

// File: tb/tb_cfg_shadow_block.sv
// Scoreboard bench for cfg_shadow_block with CFG_SIZE=10, BUS_W=4, ID_WIDTH=3, ID=5.
module tb_cfg_shadow_block;

  localparam int CFG_SIZE = 10;
  localparam int BUS_W    = 4;
  localparam int ID_WIDTH = 3;
  localparam int ID       = 5;

  logic                clk = 1'b0;
  logic                crst;
  logic                cfg_in_start;
  logic [BUS_W-1:0]    cfg_in_data;
  logic                cfg_in_valid;
  logic                cfg_out_start;
  logic [BUS_W-1:0]    cfg_out_data;
  logic                cfg_out_valid;
  logic [CFG_SIZE-1:0] cfg;
  logic                cfg_sr_pulse;
  logic                cfg_busy;
  logic                cfg_err;

  typedef struct {
    logic             s;
    logic [BUS_W-1:0] d;
    int               due;
  } beat_t;

  beat_t               exp_q[$];
  logic [CFG_SIZE-1:0] pulse_q[$];
  beat_t               e;
  logic [CFG_SIZE-1:0] pe;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  cfg_shadow_block #(
    .CFG_SIZE (CFG_SIZE),
    .BUS_W    (BUS_W),
    .ID_WIDTH (ID_WIDTH),
    .ID       (ID)
  ) dut (
    .clk           (clk),
    .crst          (crst),
    .cfg_in_start  (cfg_in_start),
    .cfg_in_data   (cfg_in_data),
    .cfg_in_valid  (cfg_in_valid),
    .cfg_out_start (cfg_out_start),
    .cfg_out_data  (cfg_out_data),
    .cfg_out_valid (cfg_out_valid),
    .cfg           (cfg),
    .cfg_sr_pulse  (cfg_sr_pulse),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: every out beat and every commit pulse is matched against the queues.
  always @(negedge clk) begin
    if (cfg_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected: got start=%0b data=%0h at cyc %0d, want no beat",
                 cfg_out_start, cfg_out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.s !== cfg_out_start || e.d !== cfg_out_data || e.due != cyc) begin
          errors++;
          $display("FAIL out_beat: got start=%0b data=%0h cyc=%0d, want start=%0b data=%0h cyc=%0d",
                   cfg_out_start, cfg_out_data, cyc, e.s, e.d, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL out_beat missing: got no beat at cyc %0d, want start=%0b data=%0h",
               cyc, e.s, e.d);
    end
    if (cfg_sr_pulse) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL commit_pulse unexpected: got pulse with cfg=%0h at cyc %0d, want none", cfg, cyc);
      end else begin
        pe = pulse_q.pop_front();
        if (cfg !== pe) begin
          errors++;
          $display("FAIL commit_cfg: got %0h, want %0h", cfg, pe);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic s, input logic [BUS_W-1:0] d);
    @(negedge clk);
    cfg_in_valid = 1'b1;
    cfg_in_start = s;
    cfg_in_data  = d;
    exp_q.push_back('{s: s, d: d, due: cyc + 1});
  endtask

  task automatic send_drop(input logic s, input logic [BUS_W-1:0] d);
    @(negedge clk);
    cfg_in_valid = 1'b1;
    cfg_in_start = s;
    cfg_in_data  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    cfg_in_valid = 1'b0;
    cfg_in_start = 1'b0;
    cfg_in_data  = '0;
  endtask

  // Readback frame for a read header accepted in cycle c: {ID,op=1} then cfg nibbles LSB-first.
  task automatic exp_resp(input int c, input logic [CFG_SIZE-1:0] v);
    logic [11:0] pad;
    pad = {2'b00, v};
    exp_q.push_back('{s: 1'b1, d: 4'hB,      due: c + 2});
    exp_q.push_back('{s: 1'b0, d: pad[3:0],  due: c + 3});
    exp_q.push_back('{s: 1'b0, d: pad[7:4],  due: c + 4});
    exp_q.push_back('{s: 1'b0, d: pad[11:8], due: c + 5});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    crst         = 1'b1;
    cfg_in_valid = 1'b0;
    cfg_in_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    crst         = 1'b1;
    cfg_in_valid = 1'b0;
    cfg_in_start = 1'b0;
    cfg_in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_cfg", 32'(cfg), 32'h0);
    chk("rst_pulse", 32'(cfg_sr_pulse), 32'h0);
    chk("rst_busy", 32'(cfg_busy), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_out", {29'h0, cfg_out_valid, cfg_out_start, 1'b0} | 32'(cfg_out_data), 32'h0);
    crst = 1'b0;

    // write 0x123 to node 5
    send(1'b1, 4'hA);
    send(1'b0, 4'h3);
    send(1'b0, 4'h2);
    pulse_q.push_back(10'h123);
    send(1'b0, 4'h1);
    idle();
    chk("write_cfg", 32'(cfg), 32'h123);
    idle();
    chk("write_busy", 32'(cfg_busy), 32'h0);

    // write addressed to node 6 passes through untouched
    send(1'b1, 4'hC);
    send(1'b0, 4'h4);
    send(1'b0, 4'h5);
    send(1'b0, 4'h6);
    idle();
    idle();
    chk("mismatch_cfg", 32'(cfg), 32'h123);
    chk("mismatch_busy", 32'(cfg_busy), 32'h0);

    // readback
    send(1'b1, 4'hB);
    exp_resp(cyc, 10'h123);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("resp_busy", 32'(cfg_busy), 32'h1);
    end
    idle();
    chk("resp_done_busy", 32'(cfg_busy), 32'h0);
    chk("resp_err", 32'(cfg_err), 32'h0);

    // aborted write followed by a complete one
    send(1'b1, 4'hA);
    send(1'b0, 4'h7);
    send(1'b1, 4'hA);
    send(1'b0, 4'h4);
    send(1'b0, 4'h4);
    pulse_q.push_back(10'h044);
    send(1'b0, 4'h0);
    idle();
    idle();
    chk("abort_cfg", 32'(cfg), 32'h044);
    chk("abort_err", 32'(cfg_err), 32'h1);

    pulse_reset();
    chk("rst2_cfg", 32'(cfg), 32'h0);
    chk("rst2_err", 32'(cfg_err), 32'h0);
    crst = 1'b0;

    // readback of a cleared cfg with a stray beat dropped during RESP
    send(1'b1, 4'hB);
    exp_resp(cyc, 10'h000);
    send_drop(1'b0, 4'h5);
    repeat (4) idle();
    chk("drop_err", 32'(cfg_err), 32'h1);

    // write with two idle cycles between beats
    send(1'b1, 4'hA);
    idle(); idle();
    send(1'b0, 4'h9);
    idle(); idle();
    send(1'b0, 4'h8);
    idle(); idle();
    pulse_q.push_back(10'h389);
    send(1'b0, 4'h3);
    idle(); idle();
    chk("gap_cfg", 32'(cfg), 32'h389);
    chk("gap_busy", 32'(cfg_busy), 32'h0);

    // reset in the middle of a write frame
    send(1'b1, 4'hA);
    send(1'b0, 4'h1);
    send(1'b0, 4'h2);
    pulse_reset();
    chk("midrst_cfg", 32'(cfg), 32'h0);
    chk("midrst_busy", 32'(cfg_busy), 32'h0);
    chk("midrst_out_valid", 32'(cfg_out_valid), 32'h0);
    crst = 1'b0;
    send(1'b0, 4'h3);
    idle(); idle();
    chk("midrst_no_commit", 32'(cfg), 32'h0);

    repeat (3) idle();
    chk("beats_drained", 32'(exp_q.size()), 32'h0);
    chk("pulses_drained", 32'(pulse_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
